// File: rtl/key_bank_debouncer_pkg.sv
// Shared types, default parameters and width helpers for the key bank debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } key_state_e;

  localparam int DEF_N_KEYS     = 8;
  localparam int DEF_STABLE_CNT = 4;
  localparam int DEF_HOLD_CNT   = 500;
  localparam int DEF_REPEAT_CNT = 100;

  // Never returns 0 so counters and codes always have at least one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int code_width(input int n_keys);
    return clog2_min1(n_keys);
  endfunction

  function automatic int dcnt_width(input int stable_cnt);
    return clog2_min1(stable_cnt);
  endfunction

  function automatic int hcnt_width(input int hold_cnt, input int repeat_cnt);
    return clog2_min1((hold_cnt > repeat_cnt) ? hold_cnt : repeat_cnt);
  endfunction

endpackage

// File: rtl/key_bank_debouncer_if.sv
// Raw key inputs and debounced event outputs of the key bank.
interface key_bank_debouncer_if #(
  parameter int N_KEYS = key_pkg::DEF_N_KEYS
);
  localparam int CODE_W = key_pkg::code_width(N_KEYS);

  logic [N_KEYS-1:0] but_in;
  logic [N_KEYS-1:0] key_active;
  logic [N_KEYS-1:0] key_posedge;
  logic [N_KEYS-1:0] key_negedge;
  logic [N_KEYS-1:0] key_hold;
  logic [N_KEYS-1:0] key_held;
  logic [N_KEYS-1:0] key_repeat;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;

  modport master (
    output but_in,
    input  key_active, key_posedge, key_negedge, key_hold, key_held, key_repeat,
    input  key_valid, key_code
  );

  modport slave (
    input  but_in,
    output key_active, key_posedge, key_negedge, key_hold, key_held, key_repeat,
    output key_valid, key_code
  );
endinterface

// File: rtl/key_bank_debouncer_channel.sv
// One key: synchroniser, stability filter, press/hold/repeat FSM and pulses.
// state    | meaning
// RELEASED | debounced level low
// PRESSED  | accepted press, hcnt counting toward the hold event
// HELD     | hold reached, hcnt cycling for auto-repeat
module key_bank_debouncer_channel
  import key_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic slow_clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_active,
  output logic o_active_nxt,
  output logic o_posedge,
  output logic o_negedge,
  output logic o_hold,
  output logic o_held,
  output logic o_repeat
);
  localparam int DW = dcnt_width(STABLE_CNT);
  localparam int HW = hcnt_width(HOLD_CNT, REPEAT_CNT);

  logic          r_sync1, r_sync2, r_stable;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  key_state_e    r_state, w_state_nxt;
  logic          w_toggle, w_rise, w_fall, w_hold_nxt, w_repeat_nxt;
  logic          r_pos, r_neg, r_hold, r_repeat;

  assign w_toggle     = (r_sync2 != r_stable) && (r_dcnt == DW'(STABLE_CNT - 1));
  assign w_rise       = w_toggle & ~r_stable;
  assign w_fall       = w_toggle & r_stable;
  assign o_active_nxt = r_stable ^ w_toggle;

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_dcnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_dcnt <= '0;
      end else if (w_toggle) begin
        r_stable <= ~r_stable;
        r_dcnt   <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  // A falling filter output always takes priority over hold/repeat.
  always_comb begin
    w_state_nxt  = r_state;
    w_hcnt_nxt   = r_hcnt;
    w_hold_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_hcnt_nxt  = '0;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt = RELEASED;
          w_hcnt_nxt  = '0;
        end else if (r_hcnt == HW'(HOLD_CNT - 1)) begin
          w_state_nxt = HELD;
          w_hcnt_nxt  = '0;
          w_hold_nxt  = 1'b1;
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt = RELEASED;
          w_hcnt_nxt  = '0;
        end else if (r_hcnt == HW'(REPEAT_CNT - 1)) begin
          w_hcnt_nxt   = '0;
          w_repeat_nxt = 1'b1;
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RELEASED;
      r_hcnt   <= '0;
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
      r_hold   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_pos    <= w_rise;
      r_neg    <= w_fall;
      r_hold   <= w_hold_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  assign o_active  = r_stable;
  assign o_posedge = r_pos;
  assign o_negedge = r_neg;
  assign o_hold    = r_hold;
  assign o_held    = (r_state == HELD);
  assign o_repeat  = r_repeat;
endmodule

// File: rtl/key_bank_debouncer.sv
// Multi-channel key debouncer: per-key channels plus a lowest-index key encoder.
module key_bank_debouncer
  import key_pkg::*;
#(
  parameter int N_KEYS     = DEF_N_KEYS,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic                 slow_clk,
  input  logic                 rst_n,
  key_bank_debouncer_if.slave  bus
);
  localparam int CODE_W = code_width(N_KEYS);

  if (N_KEYS < 1) begin : g_chk_keys
    $error("N_KEYS must be >= 1");
  end
  if (STABLE_CNT < 1) begin : g_chk_stable
    $error("STABLE_CNT must be >= 1");
  end
  if (HOLD_CNT < 2) begin : g_chk_hold
    $error("HOLD_CNT must be >= 2");
  end
  if (REPEAT_CNT < 1) begin : g_chk_repeat
    $error("REPEAT_CNT must be >= 1");
  end

  logic [N_KEYS-1:0] w_active, w_active_nxt, w_pos, w_neg, w_hold, w_held, w_repeat;
  logic [CODE_W-1:0] w_code_nxt, r_code;
  logic              r_valid;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_bank_debouncer_channel #(
      .STABLE_CNT (STABLE_CNT),
      .HOLD_CNT   (HOLD_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_ch (
      .slow_clk     (slow_clk),
      .rst_n        (rst_n),
      .i_raw        (bus.but_in[g]),
      .o_active     (w_active[g]),
      .o_active_nxt (w_active_nxt[g]),
      .o_posedge    (w_pos[g]),
      .o_negedge    (w_neg[g]),
      .o_hold       (w_hold[g]),
      .o_held       (w_held[g]),
      .o_repeat     (w_repeat[g])
    );
  end

  // Scan from the top so the lowest set index is the last write.
  always_comb begin
    w_code_nxt = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_active_nxt[i]) w_code_nxt = CODE_W'(i);
    end
  end

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_valid <= |w_active_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign bus.key_active  = w_active;
  assign bus.key_posedge = w_pos;
  assign bus.key_negedge = w_neg;
  assign bus.key_hold    = w_hold;
  assign bus.key_held    = w_held;
  assign bus.key_repeat  = w_repeat;
  assign bus.key_valid   = r_valid;
  assign bus.key_code    = r_code;
endmodule
